patch_row_collector: RTL and testbench

Read-side companion to the patch row matchers. Drains the asymmetric matcher FIFOs (one 13-bit word per read: valid flag plus 12-bit pixel) on the `rd_clk` domain. Round-robin arbitrates among N matchers and locks onto one until a full patch row of PATCH_SIZE valid pixels is assembled. Presents that row downstream with a valid/ready handshake.

---
 rtl/patch_row_collector.sv | 141 ++++++++++++++
 tb/tb_patch_row_collector.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_row_collector.sv
// Round-robin collector: locks onto one matcher FIFO until PATCH_SIZE valid pixels form a row.
// Optional discard counter is built only when PATCH_ROW_COLLECTOR_DISCARD_CNT_EN is defined.
module patch_row_slot #(
  parameter int PIXEL_SIZE = 12
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [PIXEL_SIZE-1:0] din,
  output logic [PIXEL_SIZE-1:0] q
);
  always_ff @(posedge rd_clk) begin
    if (reset)   q <= '0;
    else if (we) q <= din;
  end
endmodule

module patch_row_collector #(
  parameter int N_MATCHER  = 4,
  parameter int PATCH_SIZE = 6,
  parameter int PIXEL_SIZE = 12,
  localparam int IDW = (N_MATCHER > 1) ? $clog2(N_MATCHER) : 1,
  localparam int CW  = $clog2(PATCH_SIZE + 1)
) (
  input  logic                             rd_clk,
  input  logic                             reset,
  input  logic [N_MATCHER-1:0]             somepixel_pending,
  input  logic [N_MATCHER-1:0]             matched_pixel_valid,
  input  logic [N_MATCHER*PIXEL_SIZE-1:0]  matched_pixel,
  output logic [N_MATCHER-1:0]             pixel_ack,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [IDW-1:0]                   row_id,
  output logic [PATCH_SIZE*PIXEL_SIZE-1:0] row_data,
  output logic [15:0]                      discard_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  sel;
  logic [CW-1:0]   count;

  logic [PIXEL_SIZE-1:0] pix_arr [N_MATCHER];
  logic                  req_hit;
  logic [IDW-1:0]        req_idx;
  logic [IDW-1:0]        cand;
  logic                  acked;
  logic                  take;

  for (genvar i = 0; i < N_MATCHER; i++) begin : g_unpack
    assign pix_arr[i] = matched_pixel[i*PIXEL_SIZE +: PIXEL_SIZE];
  end

  // Rotating priority search; explicit wrap keeps non-power-of-2 counts in range.
  always_comb begin
    req_hit = 1'b0;
    req_idx = '0;
    cand    = rr_ptr;
    for (int k = 0; k < N_MATCHER; k++) begin
      if (!req_hit && somepixel_pending[cand]) begin
        req_hit = 1'b1;
        req_idx = cand;
      end
      cand = (cand == IDW'(N_MATCHER - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    pixel_ack = '0;
    if (!reset && state == S_COLLECT) pixel_ack[sel] = somepixel_pending[sel];
  end

  assign acked = |pixel_ack;
  assign take  = acked && matched_pixel_valid[sel];

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      count     <= '0;
      row_valid <= 1'b0;
      row_id    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_hit) begin
            sel   <= req_idx;
            count <= '0;
            state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (take) begin
            if (count == CW'(PATCH_SIZE - 1)) begin
              count     <= '0;
              row_valid <= 1'b1;
              row_id    <= sel;
              state     <= S_OUTPUT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_OUTPUT: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            rr_ptr    <= (sel == IDW'(N_MATCHER - 1)) ? '0 : sel + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One register slot per pixel position; the slot matching count captures the pixel.
  for (genvar k = 0; k < PATCH_SIZE; k++) begin : g_slot
    patch_row_slot #(.PIXEL_SIZE(PIXEL_SIZE)) u_slot (
      .rd_clk (rd_clk),
      .reset  (reset),
      .we     (take && (count == CW'(k))),
      .din    (pix_arr[sel]),
      .q      (row_data[k*PIXEL_SIZE +: PIXEL_SIZE])
    );
  end

`ifdef PATCH_ROW_COLLECTOR_DISCARD_CNT_EN
  logic drop;
  assign drop = acked && !matched_pixel_valid[sel];

  always_ff @(posedge rd_clk) begin
    if (reset)                            discard_cnt <= '0;
    else if (drop && discard_cnt != 16'hFFFF) discard_cnt <= discard_cnt + 16'd1;
  end
`else
  assign discard_cnt = '0;
`endif

endmodule

// File: tb/tb_patch_row_collector.sv
// Bench for patch_row_collector: FIFO queues feed the DUT, a transaction-level model predicts outputs.
module tb_patch_row_collector;
  localparam int N = 4;
  localparam int P = 6;
  localparam int W = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  pend;
  logic [N-1:0]  mvalid;
  logic [N*W-1:0] mpix;
  logic [N-1:0]  ack;
  logic          row_valid;
  logic          row_ready;
  logic [1:0]    row_id;
  logic [P*W-1:0] row_data;
  logic [15:0]   disc;

  always #5 clk = ~clk;

  patch_row_collector #(.N_MATCHER(N), .PATCH_SIZE(P), .PIXEL_SIZE(W)) dut (
    .rd_clk              (clk),
    .reset               (reset),
    .somepixel_pending   (pend),
    .matched_pixel_valid (mvalid),
    .matched_pixel       (mpix),
    .pixel_ack           (ack),
    .row_valid           (row_valid),
    .row_ready           (row_ready),
    .row_id              (row_id),
    .row_data            (row_data),
    .discard_cnt         (disc)
  );

  // FIFO contents: {valid, pixel}
  logic [12:0] fq [N][$];

  // behavioural model
  int          m_lock;
  logic [11:0] m_pix [$];
  bit          m_out;
  logic [1:0]  m_id;
  logic [P*W-1:0] m_data;
  int          m_ptr;
  int          m_disc;
  bit          armed;

  int total, bad, cyc;
  int ackcnt [N];
  int ack_first [N];
  int ack_last [N];
  int rl_id [$];
  logic [P*W-1:0] rl_data [$];
  int rl_cyc [$];
  bit feed_rand;

  logic [N-1:0]   s_ack;
  logic           s_valid;
  logic [1:0]     s_id;
  logic [P*W-1:0] s_data;
  logic [15:0]    s_disc;

  task automatic chk(input string nm, input logic [P*W-1:0] a, input logic [P*W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout got=expired want=done (cycle %0d)", nm, cyc);
  endtask

  task automatic push(input int f, input bit v, input logic [11:0] p);
    fq[f].push_back({v, p});
  endtask

  task automatic cycle(input bit rst, input bit rdy);
    logic [N-1:0] eack;
    logic [12:0]  w;
    bit           found;
    int           j;
    @(negedge clk);
    reset     = rst;
    row_ready = rdy;
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() > 0) begin
        w = fq[i][0];
        pend[i] = 1'b1;
        mvalid[i] = w[12];
        mpix[i*W +: W] = w[11:0];
      end else begin
        pend[i] = 1'b0;
        mvalid[i] = 1'($urandom);
        mpix[i*W +: W] = 12'($urandom);
      end
    end
    #1;
    eack = '0;
    if (!rst && !m_out && m_lock >= 0 && pend[m_lock]) eack[m_lock] = 1'b1;
    s_ack = ack; s_valid = row_valid; s_id = row_id; s_data = row_data; s_disc = disc;
    if (armed) begin
      chk("ack", ack, eack);
      chk("row_valid", row_valid, m_out);
      if (m_out) begin
        chk("row_id", row_id, m_id);
        chk("row_data", row_data, m_data);
      end
      chk("discard_cnt", disc, m_disc);
    end
    for (int i = 0; i < N; i++)
      if (ack[i]) begin
        if (ackcnt[i] == 0) ack_first[i] = cyc;
        ack_last[i] = cyc;
        ackcnt[i]++;
      end
    if (row_valid && rdy && !rst) begin
      rl_id.push_back(int'(row_id));
      rl_data.push_back(row_data);
      rl_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_lock = -1; m_pix.delete(); m_out = 0; m_id = 0; m_data = '0;
      m_ptr = 0; m_disc = 0; armed = 1;
    end else if (m_out) begin
      if (rdy) begin
        m_out = 0;
        m_ptr = (m_lock + 1) % N;
        m_lock = -1;
      end
    end else if (m_lock >= 0) begin
      if (eack != 0) begin
        w = fq[m_lock].pop_front();
        if (w[12]) begin
          m_pix.push_back(w[11:0]);
          if (m_pix.size() == P) begin
            for (int k = 0; k < P; k++) m_data[k*W +: W] = m_pix[k];
            m_pix.delete();
            m_out = 1;
            m_id = 2'(m_lock);
          end
        end else begin
`ifdef PATCH_ROW_COLLECTOR_DISCARD_CNT_EN
          if (m_disc < 65535) m_disc++;
`endif
        end
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && pend[j]) begin
          found = 1;
          m_lock = j;
        end
      end
    end
    if (feed_rand)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0 && fq[i].size() < 16)
          push(i, $urandom_range(0, 3) != 0, 12'($urandom));
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      ackcnt[i] = 0; ack_first[i] = 0; ack_last[i] = 0;
    end
    cycle(1, 0);
    cycle(1, 0);
    rl_id.delete(); rl_data.delete(); rl_cyc.delete();
  endtask

  task automatic run_rows(input int n, input bit rdy, input int bound, input string nm);
    int c;
    c = 0;
    while (rl_id.size() < n && c < bound) begin
      cycle(0, rdy);
      c++;
    end
    if (rl_id.size() < n) timeout_fail(nm);
  endtask

  task automatic check_zero_outputs(input string nm);
    chk({nm, "_valid"}, s_valid, 0);
    chk({nm, "_data"}, s_data, 0);
    chk({nm, "_id"}, s_id, 0);
    chk({nm, "_disc"}, s_disc, 0);
    chk({nm, "_ack"}, s_ack, 0);
  endtask

  initial begin
    int c, a0;
    total = 0; bad = 0; cyc = 0; armed = 0; feed_rand = 0;
    m_lock = -1; m_out = 0; m_ptr = 0; m_disc = 0; m_id = 0; m_data = '0;
    reset = 1; row_ready = 0; pend = '0; mvalid = '0; mpix = '0;

    // reset state
    reset_dut();
    cycle(0, 0);
    check_zero_outputs("reset");

    // single row from FIFO 2
    reset_dut();
    for (int k = 1; k <= 6; k++) push(2, 1, 12'(k));
    run_rows(1, 1, 40, "t1_row");
    chk("t1_acks", ackcnt[2], 6);
    chk("t1_consec", ack_last[2] - ack_first[2], 5);
    chk("t1_id", rl_id[0], 2);
    chk("t1_data", rl_data[0], 72'h006005004003002001);

    // interleaved invalid words: V,I,V,V,I,V,V,V
    reset_dut();
    push(0, 1, 12'h0A1); push(0, 0, 12'h7FF); push(0, 1, 12'h0A2); push(0, 1, 12'h0A3);
    push(0, 0, 12'h555); push(0, 1, 12'h0A4); push(0, 1, 12'h0A5); push(0, 1, 12'h0A6);
    run_rows(1, 1, 40, "t2_row");
    chk("t2_acks", ackcnt[0], 8);
    chk("t2_data", rl_data[0], 72'h0A60A50A40A30A20A1);
`ifdef PATCH_ROW_COLLECTOR_DISCARD_CNT_EN
    chk("t2_disc", s_disc, 2);
`else
    chk("t2_disc", s_disc, 0);
`endif

    // round robin with all FIFOs loaded
    reset_dut();
    for (int f = 0; f < N; f++)
      for (int k = 0; k < ((f == 0) ? 12 : 6); k++) push(f, 1, 12'(f * 256 + k));
    run_rows(5, 1, 100, "t3_rows");
    for (int k = 0; k < 5; k++) chk("t3_id", rl_id[k], k % N);
    for (int k = 1; k < 5; k++) chk("t3_gap", rl_cyc[k] - rl_cyc[k-1], 8);

    // stall on selected FIFO, then backpressure
    reset_dut();
    for (int k = 1; k <= 3; k++) push(1, 1, 12'(16'h110 + k));
    c = 0;
    while (ackcnt[1] < 3 && c < 20) begin cycle(0, 0); c++; end
    if (ackcnt[1] < 3) timeout_fail("t4_first3");
    for (int k = 0; k < 6; k++) push(3, 1, 12'(16'h300 + k));
    repeat (10) cycle(0, 0);
    chk("t4_no_ack3", ackcnt[3], 0);
    for (int k = 4; k <= 6; k++) push(1, 1, 12'(16'h110 + k));
    c = 0;
    while (!s_valid && c < 20) begin cycle(0, 0); c++; end
    if (!s_valid) timeout_fail("t4_valid");
    a0 = ackcnt[0] + ackcnt[1] + ackcnt[2] + ackcnt[3];
    repeat (5) begin
      cycle(0, 0);
      chk("t4_hold_valid", s_valid, 1);
      chk("t4_hold_data", s_data, 72'h116115114113112111);
    end
    chk("t4_no_ack", ackcnt[0] + ackcnt[1] + ackcnt[2] + ackcnt[3], a0);
    chk("t4_no_ack3b", ackcnt[3], 0);
    run_rows(2, 1, 40, "t4_rows");
    chk("t4_id0", rl_id[0], 1);
    chk("t4_id1", rl_id[1], 3);

    // reset mid-row
    reset_dut();
    for (int k = 1; k <= 6; k++) push(1, 1, 12'(16'h100 + k));
    c = 0;
    while (ackcnt[1] < 4 && c < 20) begin cycle(0, 1); c++; end
    if (ackcnt[1] < 4) timeout_fail("t5_four");
    cycle(1, 1);
    chk("t5_rst_ack", s_ack, 0);
    cycle(0, 1);
    check_zero_outputs("t5_after");
    for (int k = 1; k <= 4; k++) push(1, 1, 12'(16'h200 + k));
    run_rows(1, 1, 40, "t5_row");
    chk("t5_id", rl_id[0], 1);
    chk("t5_data", rl_data[0], 72'h204203202201106105);

    // randomized traffic, random ready, rare resets
    reset_dut();
    feed_rand = 1;
    repeat (3000) cycle($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0);
    feed_rand = 0;
    chk("t6_rows_seen", rl_id.size() > 10, 1);

`ifdef PATCH_ROW_COLLECTOR_DISCARD_CNT_EN
    // saturation
    reset_dut();
    c = 0;
    while (ackcnt[0] < 65540 && c < 66000) begin
      if (fq[0].size() < 2) push(0, 0, 12'($urandom));
      cycle(0, 1);
      c++;
    end
    if (ackcnt[0] < 65540) timeout_fail("t7_feed");
    fq[0].delete();
    cycle(0, 1);
    chk("t7_sat", s_disc, 16'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
